// File: rtl/irda_fir_pkg.sv
// irda_fir_pkg: shared state encoding, FIR chip patterns and 4PPM dibit lookup.
package irda_fir_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_START_FLAG,
        ST_DATA,
        ST_STOP_FLAG
    } fir_state_e;

    localparam logic [15:0] FIR_PREAMBLE_SYM = 16'b1000_0000_1010_1000;
    localparam logic [31:0] FIR_START_FLAG   = 32'b0000_1100_0000_1100_0110_0000_0110_0000;
    localparam logic [31:0] FIR_STOP_FLAG    = 32'b0000_1100_0000_1100_0000_0110_0000_0110;

    // One-hot chip position, MSB emitted first: 00->1000 ... 11->0001.
    function automatic logic [3:0] ppm4_enc(input logic [1:0] dibit);
        return 4'b1000 >> dibit;
    endfunction
endpackage

// File: rtl/irda_fir_4ppm_tx_if.sv
// irda_fir_4ppm_tx_if: byte stream from the transmit FIFO into the FIR framer.
interface irda_fir_4ppm_tx_if;
    logic [7:0] data_i;
    logic       data_valid;
    logic       data_last;
    logic       data_ready;

    modport master (output data_i, data_valid, data_last, input data_ready);
    modport slave  (input data_i, data_valid, data_last, output data_ready);
endinterface

// File: rtl/irda_4ppm_sym_enc.sv
// irda_4ppm_sym_enc: combinational 4PPM encoder, one dibit to a 4-chip group.
module irda_4ppm_sym_enc
    import irda_fir_pkg::*;
(
    input  logic [1:0] dibit,
    output logic [3:0] chips
);
    always_comb chips = ppm4_enc(dibit);
endmodule

// File: rtl/irda_fir_4ppm_tx.sv
// irda_fir_4ppm_tx: FIR 4PPM framer emitting preamble, start flag, data and stop flag
// one chip per fir_tx8_enable strobe.
module irda_fir_4ppm_tx
    import irda_fir_pkg::*;
#(
    parameter int PREAMBLE_REPS = 16
) (
    input  logic                     clk,
    input  logic                     wb_rst_n,
    input  logic                     fir_mode,
    input  logic                     fir_tx8_enable,
    input  logic                     start,
    irda_fir_4ppm_tx_if.slave        bus,
    output logic                     tx_o,
    output logic                     busy,
    output logic                     underrun
);
    fir_state_e state_q, state_d;
    logic [4:0] chip_q, chip_d;
    logic [7:0] rep_q, rep_d;
    logic [7:0] byte_q, byte_d;
    logic       last_q, last_d;
    logic       pend_q, pend_d;
    logic       tx_q, tx_d;
    logic       need;
    logic [1:0] dibit;
    logic [3:0] sym;

    irda_4ppm_sym_enc u_enc (.dibit(dibit), .chips(sym));

    assign tx_o = tx_q;
    assign busy = (state_q != ST_IDLE) | pend_q;

    always_comb begin
        state_d        = state_q;
        chip_d         = chip_q;
        rep_d          = rep_q;
        byte_d         = byte_q;
        last_d         = last_q;
        pend_d         = pend_q;
        tx_d           = tx_q;
        need           = (state_q == ST_DATA) && (chip_q[3:0] == 4'd0);
        bus.data_ready = fir_mode & fir_tx8_enable & need;
        underrun       = bus.data_ready & ~bus.data_valid;
        // First chip of a byte comes straight from the incoming byte, not the latch.
        dibit          = need ? bus.data_i[1:0] : byte_q[{chip_q[3:2], 1'b0} +: 2];
        if (!fir_mode) begin
            state_d = ST_IDLE;
            chip_d  = '0;
            rep_d   = '0;
            pend_d  = 1'b0;
            tx_d    = 1'b0;
        end else begin
            if (state_q == ST_IDLE && start) pend_d = 1'b1;
            if (fir_tx8_enable) begin
                case (state_q)
                    ST_IDLE: begin
                        tx_d = pend_q ? FIR_PREAMBLE_SYM[15] : 1'b0;
                        if (pend_q) begin
                            state_d = ST_PREAMBLE;
                            chip_d  = 5'd1;
                            rep_d   = '0;
                            pend_d  = 1'b0;
                        end
                    end
                    ST_PREAMBLE: begin
                        tx_d   = FIR_PREAMBLE_SYM[4'd15 - chip_q[3:0]];
                        chip_d = {1'b0, chip_q[3:0] + 4'd1};
                        if (chip_q[3:0] == 4'd15) begin
                            rep_d = rep_q + 8'd1;
                            if (rep_q == 8'(PREAMBLE_REPS - 1)) begin
                                state_d = ST_START_FLAG;
                                rep_d   = '0;
                            end
                        end
                    end
                    ST_START_FLAG: begin
                        tx_d   = FIR_START_FLAG[5'd31 - chip_q];
                        chip_d = chip_q + 5'd1;
                        if (chip_q == 5'd31) state_d = ST_DATA;
                    end
                    ST_DATA: begin
                        if (need && !bus.data_valid) begin
                            state_d = ST_STOP_FLAG;
                            chip_d  = '0;
                            tx_d    = 1'b0;
                        end else begin
                            tx_d   = sym[2'd3 - chip_q[1:0]];
                            chip_d = {1'b0, chip_q[3:0] + 4'd1};
                            if (need) begin
                                byte_d = bus.data_i;
                                last_d = bus.data_last;
                            end
                            if (chip_q[3:0] == 4'd15 && last_q) state_d = ST_STOP_FLAG;
                        end
                    end
                    ST_STOP_FLAG: begin
                        tx_d   = FIR_STOP_FLAG[5'd31 - chip_q];
                        chip_d = chip_q + 5'd1;
                        if (chip_q == 5'd31) state_d = ST_IDLE;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q <= ST_IDLE;
            chip_q  <= '0;
            rep_q   <= '0;
            byte_q  <= '0;
            last_q  <= 1'b0;
            pend_q  <= 1'b0;
            tx_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            chip_q  <= chip_d;
            rep_q   <= rep_d;
            byte_q  <= byte_d;
            last_q  <= last_d;
            pend_q  <= pend_d;
            tx_q    <= tx_d;
        end
    end
endmodule

// File: tb/tb_irda_fir_4ppm_tx.sv
// tb_irda_fir_4ppm_tx: directed checks of framing, 4PPM encoding, underrun, abort and reset.
module tb_irda_fir_4ppm_tx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic fir_mode = 1'b0;
    logic en = 1'b0;
    logic start = 1'b0;
    logic tx_o, busy, underrun;
    int checks = 0;
    int errors = 0;
    logic [31:0] v;
    int r, u, idle;
    logic c, cr, cu;

    irda_fir_4ppm_tx_if bus ();

    irda_fir_4ppm_tx #(.PREAMBLE_REPS(2)) dut (
        .clk(clk),
        .wb_rst_n(rst_n),
        .fir_mode(fir_mode),
        .fir_tx8_enable(en),
        .start(start),
        .bus(bus),
        .tx_o(tx_o),
        .busy(busy),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One chip period: four idle clocks then a strobe clock; ready/underrun sampled mid-strobe.
    task automatic chip(output logic ch, output logic rdy, output logic und);
        repeat (4) tick();
        en = 1'b1;
        #1;
        rdy = bus.data_ready;
        und = underrun;
        tick();
        en = 1'b0;
        ch = tx_o;
    endtask

    task automatic chips(input int n, output logic [31:0] vec, output int rdy, output int und, output int nb);
        logic a, b, d;
        vec = '0;
        rdy = 0;
        und = 0;
        nb  = 0;
        for (int i = 0; i < n; i++) begin
            chip(a, b, d);
            vec = {vec[30:0], a};
            rdy += int'(b);
            und += int'(d);
            nb  += int'(!busy);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        bus.data_i = 8'h00;
        bus.data_valid = 1'b0;
        bus.data_last = 1'b0;
        repeat (3) tick();
        check("rst_tx", tx_o, 0);
        check("rst_busy", busy, 0);
        check("rst_und", underrun, 0);
        check("rst_ready", bus.data_ready, 0);
        rst_n = 1'b1;
        fir_mode = 1'b1;
        tick();

        bus.data_i = 8'hB4;
        bus.data_valid = 1'b1;
        bus.data_last = 1'b1;
        pulse_start();
        check("busy_after_start", busy, 1);
        chips(32, v, r, u, idle);
        check("preamble", v, 32'h80A8_80A8);
        check("pre_busy_low", idle, 0);
        chips(32, v, r, u, idle);
        check("start_flag", v, 32'h0C0C_6060);
        check("sf_ready", r, 0);
        check("sf_busy_low", idle, 0);
        chips(16, v, r, u, idle);
        check("data_b4", v[15:0], 16'h8412);
        check("b4_ready", r, 1);
        check("b4_und", u, 0);
        chips(32, v, r, u, idle);
        check("stop_b4", v, 32'h0C0C_0606);
        check("stop_ready", r, 0);
        tick();
        check("end_busy", busy, 0);
        check("end_tx", tx_o, 0);

        bus.data_i = 8'h00;
        bus.data_last = 1'b0;
        pulse_start();
        chips(32, v, r, u, idle);
        chips(32, v, r, u, idle);
        chips(16, v, r, u, idle);
        check("data_00", v[15:0], 16'h8888);
        check("b00_ready", r, 1);
        bus.data_i = 8'hFF;
        bus.data_last = 1'b1;
        chips(16, v, r, u, idle);
        check("data_ff", v[15:0], 16'h1111);
        check("bff_ready", r, 1);
        chips(32, v, r, u, idle);
        check("stop_ff", v, 32'h0C0C_0606);
        check("stop_ff_ready", r, 0);
        tick();
        check("end2_busy", busy, 0);

        bus.data_i = 8'h55;
        bus.data_last = 1'b0;
        pulse_start();
        chips(64, v, r, u, idle);
        chips(16, v, r, u, idle);
        check("data_55", v[15:0], 16'h4444);
        check("b55_und", u, 0);
        bus.data_valid = 1'b0;
        chip(c, cr, cu);
        check("und_pulse", cu, 1);
        check("und_ready", cr, 1);
        check("und_chip", c, 0);
        check("und_after", underrun, 0);
        chips(32, v, r, u, idle);
        check("stop_und", v, 32'h0C0C_0606);
        check("stop_und_count", u, 0);
        tick();
        check("end3_busy", busy, 0);

        bus.data_valid = 1'b1;
        pulse_start();
        chips(32, v, r, u, idle);
        chips(6, v, r, u, idle);
        check("abort_pre_sf", v[5:0], 6'b000011);
        check("abort_pre_tx", tx_o, 1);
        fir_mode = 1'b0;
        tick();
        check("abort_tx", tx_o, 0);
        check("abort_busy", busy, 0);
        fir_mode = 1'b1;
        tick();
        pulse_start();
        chips(16, v, r, u, idle);
        check("restart_pre", v[15:0], 16'h80A8);

        chips(16, v, r, u, idle);
        chips(32, v, r, u, idle);
        bus.data_i = 8'hB4;
        bus.data_last = 1'b1;
        chips(6, v, r, u, idle);
        check("mid_data_chips", v[5:0], 6'b100001);
        en = 1'b1;
        rst_n = 1'b0;
        #1;
        check("arst_tx", tx_o, 0);
        check("arst_busy", busy, 0);
        check("arst_und", underrun, 0);
        check("arst_ready", bus.data_ready, 0);
        en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        start = 1'b1;
        en = 1'b1;
        tick();
        start = 1'b0;
        en = 1'b0;
        check("coin_tx", tx_o, 0);
        check("coin_busy", busy, 1);
        chip(c, cr, cu);
        check("coin_first_chip", c, 1);
        chips(15, v, r, u, idle);
        check("coin_rest", v[14:0], 15'h00A8);
        fir_mode = 1'b0;
        tick();
        check("final_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
